spi_reg_controller: RTL and testbench
=====================================

Name: spi_reg_controller

Overview:
- SPI mode-0 target that configures the PWM peripheral's register bank: en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle.
- Sits between the top-level pins and the PWM peripheral.
- Samples the external SPI bus in the system clock domain and decodes 16-bit frames.
- Commits writes atomically on frame end and serves register reads on cipo.

Parameters:
SYNC_STAGES, 2, flop stages on each of sclk/copi/ncs before edge detection (min 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
sclk  in  1  SPI clock from controller, asynchronous to clk
copi  in  1  SPI data in, asynchronous
ncs  in  1  SPI chip select, active low, asynchronous
cipo  out  1  SPI data out (read data)
en_reg_out_7_0  out  8  register 0x00
en_reg_out_15_8  out  8  register 0x01
en_reg_pwm_7_0  out  8  register 0x02
en_reg_pwm_15_8  out  8  register 0x03
pwm_duty_cycle  out  8  register 0x04
wr_strobe  out  1  one-clk pulse on each committed write
txn_err  out  1  one-clk pulse on each discarded frame

Behaviour:
- Reset (async, rst=1): all five registers 0x00; cipo, wr_strobe, txn_err 0; FSM IDLE; bit counter 0; ncs synchronizer flops preset 1, sclk/copi flops 0.
- Synchronizers: sclk, copi and ncs each pass through SYNC_STAGES flops. Edges are detected from the last two stages. Input latency is SYNC_STAGES+1 clk.
- Supported sclk: <= clk/8. Each sclk phase must be >= 4 clk.
- Frame format: 16 bits, MSB first, sampled on sclk rising edges.
  - bit15: R/W (1 = write).
  - bits14:8: 7-bit address.
  - bits7:0: data.
- FSM states: IDLE, CMD, DATA, DONE, WAIT_HIGH.
  - IDLE -> CMD on synchronized ncs falling edge. Clears shift register and counter.
  - CMD: shift copi on each sclk rise. After the 8th rise, go to DATA and latch R/W and address.
  - DATA: shift 8 more bits. After the 16th rise, go to DONE.
  - DONE: any further sclk rise sets an overrun flag.
  - Any state except IDLE/WAIT_HIGH -> IDLE on synchronized ncs rising edge; frame is evaluated then.
- Commit, in the clk after the ncs rising edge is detected:
  - Requires count==16, no overrun, R/W=1, address <= 0x04.
  - Write data into the addressed register and pulse wr_strobe for exactly one clk.
  - Register outputs change in the same cycle wr_strobe is high.
- Discard (no register change, txn_err one-clk pulse) for any of:
  - count < 16;
  - overrun;
  - write to address >= 0x05.
- Read (R/W=0) frames with count==16 complete without strobe or error. Short read frames assert txn_err.
- Read path:
  - On the 8th sclk rise with R/W=0, load an 8-bit read shadow with the addressed register (0x00 if address >= 0x05).
  - Drive cipo = shadow[7] from the next clk onward.
  - On each subsequent synchronized sclk falling edge in DATA, shift the shadow left, so cipo presents the next bit before the next rise.
  - cipo is 0 in IDLE, CMD, write frames and after ncs rises.
- Simultaneous ncs rise and sclk rise in the same synchronized cycle: the ncs rise takes priority, and that sclk edge is not counted.
- Register values are stable except at commit; a frame aborted by ncs never disturbs them.
- Reset mid-frame: everything returns to reset values. If synchronized ncs is low when rst deasserts, the FSM enters WAIT_HIGH. It ignores sclk until ncs goes high, then returns to IDLE. No partial frame is ever committed.

Test Plan:
- Write 0x00 <- 0xF0 (frame 0x80F0), then raise ncs -> en_reg_out_7_0=0xF0 one clk after the ncs rise is detected; wr_strobe pulses once; other registers stay 0x00.
- Write 0x04 <- 0x80, then 0x04 <- 0xFF -> pwm_duty_cycle reads 0x80, then 0xFF; two wr_strobe pulses; txn_err never asserted.
- Write 0x02 <- 0xA5, then read frame 0x0200 -> cipo yields 1,0,1,0,0,1,0,1 on sclk rises 9-16; no strobe, no error; register unchanged.
- Write 0x05 <- 0x55, 12-bit frame to 0x01, and 17-bit frame to 0x03 -> all registers unchanged; txn_err pulses 3 times; wr_strobe never pulses.
- Assert rst after 10 bits of a write frame to 0x01, ncs held low, then release rst -> registers 0x00; remaining 6 bits ignored. A subsequent full frame writing 0x01 <- 0x3C after ncs toggles gives en_reg_out_15_8=0x3C.

Source files
------------

// File: rtl/spi_reg_controller.sv
// SPI mode-0 target that owns the PWM peripheral's five configuration registers.
// The SPI pins are oversampled in the clk domain; 16-bit frames commit on chip-select release.
module spi_reg_controller #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       txn_err
);

  // Handshake: there is no valid/ready pair here. A frame is the ncs-low window,
  // bits are taken on synchronized sclk rises, and a frame takes effect only at
  // the synchronized ncs rise, reported by a single-cycle wr_strobe or txn_err.

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CMD       = 3'd1,
    DATA      = 3'd2,
    DONE      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  localparam int SETTLE = SYNC_STAGES + 2;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sclk_s, copi_s, ncs_s;
  logic                   sclk_d, ncs_d;
  logic                   sclk_rise, sclk_fall, ncs_rise, ncs_fall, copi_bit;

  logic [4:0] bit_cnt;
  logic [7:0] shift_q;
  logic       rw_q;
  logic [6:0] addr_q;
  logic       overrun;
  logic [7:0] shadow;
  logic [7:0] settle_cnt;
  logic       settled;

  // Synchronizers plus one extra flop per edge-detected line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s <= '0;
      copi_s <= '0;
      ncs_s  <= '1;
      sclk_d <= 1'b0;
      ncs_d  <= 1'b1;
    end else begin
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], sclk};
      copi_s <= {copi_s[SYNC_STAGES-2:0], copi};
      ncs_s  <= {ncs_s[SYNC_STAGES-2:0], ncs};
      sclk_d <= sclk_s[SYNC_STAGES-1];
      ncs_d  <= ncs_s[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_s[SYNC_STAGES-1] & ~sclk_d;
  assign sclk_fall = ~sclk_s[SYNC_STAGES-1] & sclk_d;
  assign ncs_rise  = ncs_s[SYNC_STAGES-1] & ~ncs_d;
  assign ncs_fall  = ~ncs_s[SYNC_STAGES-1] & ncs_d;
  assign copi_bit  = copi_s[SYNC_STAGES-1];
  assign settled   = (settle_cnt == 8'd0);

  function automatic logic [7:0] read_mux(input logic [6:0] addr);
    logic [7:0] val;
    val = 8'h00;
    case (addr)
      7'h00:   val = en_reg_out_7_0;
      7'h01:   val = en_reg_out_15_8;
      7'h02:   val = en_reg_pwm_7_0;
      7'h03:   val = en_reg_pwm_15_8;
      7'h04:   val = pwm_duty_cycle;
      default: val = 8'h00;
    endcase
    return val;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic. A falling ncs seen while the synchronizers are still
  // flushing after reset means the frame started before reset: sit it out.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (ncs_fall) next_state = settled ? CMD : WAIT_HIGH;
      end
      CMD: begin
        if (ncs_rise)                           next_state = IDLE;
        else if (sclk_rise && bit_cnt == 5'd7)  next_state = DATA;
      end
      DATA: begin
        if (ncs_rise)                           next_state = IDLE;
        else if (sclk_rise && bit_cnt == 5'd15) next_state = DONE;
      end
      DONE: begin
        if (ncs_rise) next_state = IDLE;
      end
      WAIT_HIGH: begin
        if (ncs_s[SYNC_STAGES-1]) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs: cipo only carries read data once the command byte said "read".
  always_comb begin
    cipo = 1'b0;
    if ((state == DATA || state == DONE) && !rw_q) cipo = shadow[7];
  end

  // Frame datapath, register bank and commit/discard pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt         <= 5'd0;
      shift_q         <= 8'h00;
      rw_q            <= 1'b0;
      addr_q          <= 7'h00;
      overrun         <= 1'b0;
      shadow          <= 8'h00;
      settle_cnt      <= 8'(SETTLE);
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
      wr_strobe       <= 1'b0;
      txn_err         <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      txn_err   <= 1'b0;
      if (!settled) settle_cnt <= settle_cnt - 8'd1;

      case (state)
        IDLE: begin
          if (ncs_fall) begin
            bit_cnt <= 5'd0;
            shift_q <= 8'h00;
            rw_q    <= 1'b0;
            addr_q  <= 7'h00;
            overrun <= 1'b0;
            shadow  <= 8'h00;
          end
        end
        CMD, DATA, DONE: begin
          // ncs release wins over a coincident sclk rise.
          if (ncs_rise) begin
            if (state == DONE && !overrun) begin
              if (rw_q) begin
                if (addr_q <= 7'h04) begin
                  wr_strobe <= 1'b1;
                  case (addr_q[2:0])
                    3'd0:    en_reg_out_7_0  <= shift_q;
                    3'd1:    en_reg_out_15_8 <= shift_q;
                    3'd2:    en_reg_pwm_7_0  <= shift_q;
                    3'd3:    en_reg_pwm_15_8 <= shift_q;
                    default: pwm_duty_cycle  <= shift_q;
                  endcase
                end else begin
                  txn_err <= 1'b1;
                end
              end
            end else begin
              txn_err <= 1'b1;
            end
          end else if (sclk_rise) begin
            if (state == DONE) begin
              overrun <= 1'b1;
            end else begin
              shift_q <= {shift_q[6:0], copi_bit};
              bit_cnt <= bit_cnt + 5'd1;
              if (state == CMD && bit_cnt == 5'd7) begin
                rw_q   <= shift_q[6];
                addr_q <= {shift_q[5:0], copi_bit};
                if (!shift_q[6]) shadow <= read_mux({shift_q[5:0], copi_bit});
              end
            end
          end else if (sclk_fall && state == DATA && !rw_q && bit_cnt > 5'd8) begin
            // The first data bit is already on cipo at rise 9; advance after it.
            shadow <= {shadow[6:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_controller.sv
// Directed bench for spi_reg_controller: a table of SPI frames with expected register
// snapshots, pulse counts and cipo captures, plus a reset-in-mid-frame sequence.
module tb_spi_reg_controller;

  logic clk = 1'b0;
  logic rst, sclk, copi, ncs;
  logic cipo, wr_strobe, txn_err;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic [39:0] regs_now;

  int total = 0;
  int bad = 0;
  int n_strobe = 0;
  int n_err = 0;

  // Clock and reset-independent pulse monitors.
  always #5 clk = ~clk;

  spi_reg_controller #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe), .txn_err(txn_err)
  );

  assign regs_now = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};

  always @(negedge clk) begin
    if (wr_strobe) n_strobe++;
    if (txn_err)   n_err++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [16:0] frame;
    int          nbits;
    logic [39:0] exp_regs;  // {0x04, 0x03, 0x02, 0x01, 0x00}
    int          exp_str;
    int          exp_err;
    logic [15:0] exp_cipo;  // cipo just before rises 1..16, rise 1 in bit 15
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Driver tasks: inputs change on negedge, sclk phases are 8 clk long.
  task automatic start_frame();
    @(negedge clk);
    ncs = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_bits(input logic [16:0] frame, input int nbits, output logic [15:0] cap);
    cap = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      @(negedge clk);
      copi = frame[i];
      repeat (4) @(negedge clk);
      cap = {cap[14:0], cipo};
      sclk = 1'b1;
      repeat (8) @(negedge clk);
      sclk = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic end_frame(output int lat, output logic [39:0] snap_pulse, output logic [39:0] snap_pre);
    repeat (8) @(negedge clk);
    ncs = 1'b1;
    lat = -1;
    snap_pre = regs_now;
    snap_pulse = regs_now;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (lat < 0) begin
        if (wr_strobe || txn_err) begin
          lat = k;
          snap_pulse = regs_now;
        end else begin
          snap_pre = regs_now;
        end
      end
    end
    if (lat < 0) snap_pulse = regs_now;
  endtask

  initial begin
    int s0, e0, lat;
    logic [15:0] cap;
    logic [39:0] prev, snap_p, snap_pre;

    vecs[0]  = '{17'h080F0, 16, 40'h00_00_00_00_F0, 1, 0, 16'h0000};
    vecs[1]  = '{17'h08480, 16, 40'h80_00_00_00_F0, 1, 0, 16'h0000};
    vecs[2]  = '{17'h084FF, 16, 40'hFF_00_00_00_F0, 1, 0, 16'h0000};
    vecs[3]  = '{17'h082A5, 16, 40'hFF_00_A5_00_F0, 1, 0, 16'h0000};
    vecs[4]  = '{17'h00200, 16, 40'hFF_00_A5_00_F0, 0, 0, 16'h00A5};
    vecs[5]  = '{17'h08555, 16, 40'hFF_00_A5_00_F0, 0, 1, 16'h0000};
    vecs[6]  = '{17'h0081A, 12, 40'hFF_00_A5_00_F0, 0, 1, 16'h0000};
    vecs[7]  = '{17'h106EF, 17, 40'hFF_00_A5_00_F0, 0, 1, 16'h0000};
    vecs[8]  = '{17'h00400, 16, 40'hFF_00_A5_00_F0, 0, 0, 16'h00FF};
    vecs[9]  = '{17'h00700, 16, 40'hFF_00_A5_00_F0, 0, 0, 16'h0000};
    vecs[10] = '{17'h00000, 10, 40'hFF_00_A5_00_F0, 0, 1, 16'h0000};

    rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_regs", regs_now, 40'h0);
    check("reset_cipo", cipo, 1'b0);
    check("reset_wr_strobe", wr_strobe, 1'b0);
    check("reset_txn_err", txn_err, 1'b0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      s0 = n_strobe;
      e0 = n_err;
      prev = regs_now;
      start_frame();
      send_bits(vecs[i].frame, vecs[i].nbits, cap);
      end_frame(lat, snap_p, snap_pre);
      check($sformatf("row%0d_regs", i), regs_now, vecs[i].exp_regs);
      check($sformatf("row%0d_strobes", i), n_strobe - s0, vecs[i].exp_str);
      check($sformatf("row%0d_errs", i), n_err - e0, vecs[i].exp_err);
      if (vecs[i].nbits == 16)
        check($sformatf("row%0d_cipo", i), cap, vecs[i].exp_cipo);
      if (vecs[i].exp_str + vecs[i].exp_err > 0) begin
        check($sformatf("row%0d_pulse_latency", i), lat, 3);
        check($sformatf("row%0d_regs_at_pulse", i), snap_p, vecs[i].exp_regs);
        check($sformatf("row%0d_regs_before_pulse", i), snap_pre, prev);
      end
      repeat (4) @(negedge clk);
    end

    // Reset after 10 bits of a write to 0x01 with ncs held low.
    s0 = n_strobe;
    start_frame();
    send_bits(17'h00206, 10, cap);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_regs", regs_now, 40'h0);
    check("midrst_cipo", cipo, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_bits(17'h0002B, 6, cap);
    end_frame(lat, snap_p, snap_pre);
    check("midrst_tail_regs", regs_now, 40'h0);
    check("midrst_tail_strobes", n_strobe - s0, 0);
    repeat (4) @(negedge clk);

    s0 = n_strobe;
    start_frame();
    send_bits(17'h0813C, 16, cap);
    end_frame(lat, snap_p, snap_pre);
    check("after_rst_regs", regs_now, 40'h00_00_00_3C_00);
    check("after_rst_strobes", n_strobe - s0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
